accum_feeder: RTL

- Upstream stage of the 32-bit accumulator. Accepts a framed sample stream over a valid/ready handshake and buffers it in a small FIFO.
- Drives the accumulator's data/enable/clear inputs and captures the accumulator result at each frame end.
- Reports the frame sum and sample count, then clears the accumulator for the next frame.
- Accumulator contract: accum <= accum + data on a rising edge where enable=1; accum <= 0 on a rising edge where clear=1; clear has priority.

---
 rtl/accum_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/accum_feeder.sv
// Feeds a framed sample stream from a small FIFO into the 32-bit accumulator.
// At each frame end it snapshots the frame sum and sample count, then clears the accumulator.
module accum_feeder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              flush,
    output logic [DATA_W-1:0] data,
    output logic              enable,
    output logic              clear,
    input  logic [DATA_W-1:0] accum,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_data,
    output logic [CNT_W-1:0]  sum_count,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int AW = $clog2(DEPTH);

    // LAST: the final sample is on the accumulator inputs; WAIT: accum has settled.
    // The clear/sum_valid cycle overlaps FEED, so the next pop can land right after it.
    typedef enum logic [1:0] {FEED, LAST, WAIT} state_t;

    state_t            state, state_next;
    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_next;
    logic              push, pop;
    logic [DATA_W:0]   head;
    logic [CNT_W-1:0]  sample_cnt;

    assign push = s_valid && s_ready && !flush;
    assign pop  = (state == FEED) && (count != '0) && !flush;
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + (AW+1)'(1);
        else if (!push && pop)
            count_next = count - (AW+1)'(1);
    end

    always_comb begin
        state_next = state;
        if (flush)
            state_next = FEED;
        else begin
            case (state)
                FEED:    if (pop && head[DATA_W]) state_next = LAST;
                LAST:    state_next = WAIT;
                WAIT:    state_next = FEED;
                default: state_next = FEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FEED;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            s_ready <= (count_next < (AW+1)'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Enable/clear/sum_valid are single-cycle strobes; data and the sum outputs hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            enable     <= 1'b0;
            clear      <= 1'b0;
            sum_valid  <= 1'b0;
            sum_data   <= '0;
            sum_count  <= '0;
            frame_cnt  <= '0;
            sample_cnt <= '0;
        end else begin
            enable    <= 1'b0;
            clear     <= 1'b0;
            sum_valid <= 1'b0;
            if (flush) begin
                clear      <= 1'b1;
                sample_cnt <= '0;
            end else begin
                case (state)
                    FEED: begin
                        if (pop) begin
                            data   <= head[DATA_W-1:0];
                            enable <= 1'b1;
                            if (sample_cnt != '1)
                                sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                    WAIT: begin
                        clear      <= 1'b1;
                        sum_valid  <= 1'b1;
                        sum_data   <= accum;
                        sum_count  <= sample_cnt;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        sample_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
